// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [NREQ-1:0] ONEHOT4 [NREQ] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

endpackage

// File: rtl/onehot_enc4.sv
// Combinational 4-bit one-hot to 2-bit index encoder; outputs 0 when disabled.
module onehot_enc4
  import arb_pkg::*;
(
  input  logic            en,
  input  logic [NREQ-1:0] oh,
  output logic [IDW-1:0]  idx_c
);

  always_comb begin
    idx_c = '0;
    if (en) begin
      case (oh)
        4'b0001: idx_c = 2'd0;
        4'b0010: idx_c = 2'd1;
        4'b0100: idx_c = 2'd2;
        4'b1000: idx_c = 2'd3;
        default: idx_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// Round-robin arbiter for four requesters with a bounded grant tenure.
// Fairness comes from a rotating pointer that holds the most recent grantee.
module rr_arb4_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_vld
);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic [NREQ-1:0]  cand_c;
  logic             pick_found_c;
  logic [IDW-1:0]   pick_c;
  logic [IDW-1:0]   scan_idx_c;
  logic             timeout_c;
  logic             release_c;
  logic             regrant_c;
  logic [IDW-1:0]   enc_idx_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      gnt_vld_q  <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= IDW'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      gnt_vld_q  <= gnt_vld_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  // Release detection and rotating-priority scan; the holder is masked out on handoff
  always_comb begin
    timeout_c    = (hold_cnt_q == CNT_W'(MAX_HOLD));
    release_c    = (state_q == GRANT) && (!req[gnt_id_q] || done || timeout_c);
    regrant_c    = timeout_c && req[gnt_id_q] && !done;
    cand_c       = (state_q == GRANT) ? (req & ~gnt_q) : req;
    pick_found_c = 1'b0;
    pick_c       = ptr_q;
    scan_idx_c   = ptr_q;
    // Walk from lowest priority up so the highest-priority hit is written last
    for (int i = NREQ; i >= 1; i--) begin
      scan_idx_c = IDW'(ptr_q + IDW'(i));
      if (cand_c[scan_idx_c]) begin
        pick_found_c = 1'b1;
        pick_c       = scan_idx_c;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (pick_found_c) state_d = GRANT;
        GRANT:   if (release_c && !pick_found_c && !regrant_c) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Grant, hold counter and pointer updates
  always_comb begin
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    if (!en) begin
      gnt_d      = '0;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_d = '0;
          if (pick_found_c) begin
            gnt_d      = ONEHOT4[pick_c];
            hold_cnt_d = CNT_W'(1);
            ptr_d      = pick_c;
          end
        end
        GRANT: begin
          if (!release_c) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end else if (pick_found_c) begin
            gnt_d      = ONEHOT4[pick_c];
            hold_cnt_d = CNT_W'(1);
            ptr_d      = pick_c;
          end else if (regrant_c) begin
            hold_cnt_d = CNT_W'(1);
          end else begin
            gnt_d      = '0;
            hold_cnt_d = '0;
          end
        end
        default: begin
          gnt_d      = '0;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // gnt_id keeps its last value while no grant is active
  assign gnt_vld_d = |gnt_d;
  assign gnt_id_d  = gnt_vld_d ? enc_idx_c : gnt_id_q;

  onehot_enc4 u_enc (
    .en    (gnt_vld_d),
    .oh    (gnt_d),
    .idx_c (enc_idx_c)
  );

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Self-checking bench for rr_arb4_ctrl: directed vector table, async reset
// sequence and randomized traffic against a behavioural round-robin model.
module tb_rr_arb4_ctrl;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;

  always #5 clk = ~clk;

  rr_arb4_ctrl #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who holds the grant (-1 = nobody), how long, and last grantee
  int m_holder;
  int m_cnt;
  int m_ptr;
  int m_last_id;

  typedef struct {
    bit       en;
    bit [3:0] req;
    bit       done;
    bit [3:0] gnt;
    bit [1:0] id;
    bit       vld;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] mask, input int ptr);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder  = -1;
    m_cnt     = 0;
    m_ptr     = 3;
    m_last_id = 0;
  endtask

  task automatic model_step(input bit e, input logic [3:0] r, input bit d);
    int pick;
    logic [3:0] others;
    if (!e) begin
      m_holder = -1;
      m_cnt    = 0;
    end else if (m_holder < 0) begin
      pick = first_from(r, m_ptr);
      if (pick >= 0) begin
        m_holder = pick; m_cnt = 1; m_ptr = pick;
      end
    end else if (r[m_holder] && !d && m_cnt < MAX_HOLD) begin
      m_cnt++;
    end else begin
      others = r;
      others[m_holder] = 1'b0;
      pick = first_from(others, m_ptr);
      if (pick >= 0) begin
        m_holder = pick; m_cnt = 1; m_ptr = pick;
      end else if (r[m_holder] && !d && m_cnt == MAX_HOLD) begin
        m_cnt = 1;
      end else begin
        m_holder = -1; m_cnt = 0;
      end
    end
    if (m_holder >= 0) m_last_id = m_holder;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder);
    check({tag, "_gnt"}, 32'(gnt), 32'(eg));
    check({tag, "_vld"}, 32'(gnt_vld), 32'(m_holder >= 0));
    check({tag, "_id"}, 32'(gnt_id), 32'(m_last_id));
  endtask

  task automatic apply(input bit e, input logic [3:0] r, input bit d, input string tag);
    en = e; req = r; done = d;
    @(posedge clk);
    model_step(e, r, d);
    #1;
    check_model(tag);
  endtask

  task automatic add(input bit e, input logic [3:0] r, input bit d,
                     input logic [3:0] g, input logic [1:0] id, input bit v);
    vec_t v_rec;
    v_rec.en = e; v_rec.req = r; v_rec.done = d;
    v_rec.gnt = g; v_rec.id = id; v_rec.vld = v;
    vecs.push_back(v_rec);
  endtask

  initial begin
    logic [3:0] rr;
    rst_n = 1'b0; en = 1'b0; req = 4'b0000; done = 1'b0;
    model_reset();

    // Hold limit alternation between requesters 0 and 2
    for (int i = 0; i < 8; i++) add(1, 4'b0101, 0, 4'b0001, 2'd0, 1);
    for (int i = 0; i < 8; i++) add(1, 4'b0101, 0, 4'b0100, 2'd2, 1);
    add(1, 4'b0101, 0, 4'b0001, 2'd0, 1);
    // Full rotation as each holder drops its request
    add(1, 4'b1110, 0, 4'b0010, 2'd1, 1);
    add(1, 4'b1101, 0, 4'b0100, 2'd2, 1);
    add(1, 4'b1011, 0, 4'b1000, 2'd3, 1);
    add(1, 4'b0111, 0, 4'b0001, 2'd0, 1);
    add(1, 4'b1110, 0, 4'b0010, 2'd1, 1);
    // done from holder 1, then holder 3 drops
    add(1, 4'b1010, 1, 4'b1000, 2'd3, 1);
    add(1, 4'b0010, 0, 4'b0010, 2'd1, 1);
    // en drop mid-grant of requester 2; pointer retained
    add(1, 4'b0100, 0, 4'b0100, 2'd2, 1);
    add(0, 4'b0100, 0, 4'b0000, 2'd2, 0);
    add(1, 4'b1111, 0, 4'b1000, 2'd3, 1);
    // Single requester re-granted across hold limits
    for (int i = 0; i < 20; i++) add(1, 4'b0010, 0, 4'b0010, 2'd1, 1);
    add(0, 4'b0010, 0, 4'b0000, 2'd1, 0);
    add(1, 4'b0000, 1, 4'b0000, 2'd1, 0);

    #12;
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_id", 32'(gnt_id), 32'h0);
    check("reset_vld", 32'(gnt_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].en, vecs[i].req, vecs[i].done, "vec_model");
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_id", i), 32'(gnt_id), 32'(vecs[i].id));
      check($sformatf("vec%0d_vld", i), 32'(gnt_vld), 32'(vecs[i].vld));
    end

    // Asynchronous reset in the middle of a grant
    apply(1, 4'b0100, 0, "pre_rst");
    check("pre_rst_granted", 32'(gnt_vld), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h0);
    check("async_rst_vld", 32'(gnt_vld), 32'h0);
    check("async_rst_id", 32'(gnt_id), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 4'b1000, 0, "post_rst");
    check("post_rst_gnt", 32'(gnt), 32'h8);
    check("post_rst_id", 32'(gnt_id), 32'h3);

    // Random traffic with sticky requests so hold limits are reached
    rr = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) rr = 4'($urandom);
      apply($urandom_range(0, 19) != 0, rr, $urandom_range(0, 7) == 0, "rand");
      if (gnt != 4'b0000 && (gnt & (gnt - 4'd1)) != 4'b0000)
        check("onehot", 32'(gnt), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
